// File: rtl/ste_avg_pkg.sv
// Shared types and default parameters for the multimeter averaging front end.
package ste_avg_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} avg_ctrl_state_t;

  localparam int SETTLE_N_DEF    = 4;
  localparam int OUT_DIV_DEF     = 8;
  localparam int TIMEOUT_CYC_DEF = 1000000;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ste_timeout_cnt.sv
// Restartable saturating cycle counter with a sticky terminal flag.
// clr_i wipes count and flag; restart_i wipes only the count.
module ste_timeout_cnt
  import ste_avg_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic run_i,
  input  logic restart_i,
  output logic flag_o
);

  localparam int CW = cnt_w(LIMIT);
  localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr_i) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (restart_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      // Holding at the terminal value for one more cycle is what raises the flag.
      if (cnt_q == TERM) flag_d = 1'b1;
      else               cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/ste_avg_ctrl.sv
// Sequencer between the ADC sample stream and the averaging filter:
// clear, settle-discard, forward, decimate to display rate, hold, timeout.
module ste_avg_ctrl
  import ste_avg_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SETTLE_N    = SETTLE_N_DEF,
  parameter int OUT_DIV     = OUT_DIV_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              cfg_change_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] smp_i,
  input  logic              smp_update_i,
  output logic [DATA_W-1:0] avg_din_o,
  output logic              avg_din_update_o,
  output logic              avg_clr_o,
  input  logic [DATA_W-1:0] avg_dout_i,
  input  logic              avg_dout_update_i,
  output logic [DATA_W-1:0] res_o,
  output logic              res_update_o,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int SW = cnt_w(SETTLE_N + 1);
  localparam int DW = cnt_w(OUT_DIV);

  avg_ctrl_state_t state_q, state_d;

  logic [SW-1:0]     settle_q, settle_d;
  logic [DW-1:0]     dec_q, dec_d;
  logic [DATA_W-1:0] din_q, din_d, res_q, res_d;
  logic              din_upd_q, din_upd_d;
  logic              res_upd_q, res_upd_d;
  logic              clr_q, clr_d;
  logic              busy_q, busy_d;
  logic              smp_ev;
  logic              tmo_clr, tmo_run, tmo_flag;

  // A sample only counts if neither disable nor reconfiguration preempts it.
  assign smp_ev = smp_update_i && enable_i && !cfg_change_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else if (state_q == IDLE || cfg_change_i) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        CLEAR:   state_d = (SETTLE_N > 0) ? SETTLE : RUN;
        SETTLE:  if (smp_ev && settle_q == SW'(1)) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    settle_d  = settle_q;
    dec_d     = dec_q;
    din_d     = din_q;
    res_d     = res_q;
    din_upd_d = 1'b0;
    res_upd_d = 1'b0;
    clr_d     = (state_d == CLEAR);
    busy_d    = (state_d == CLEAR) || (state_d == SETTLE);
    if (state_d == CLEAR) begin
      settle_d = SW'(SETTLE_N);
      dec_d    = '0;
    end else if (state_q == SETTLE && smp_ev) begin
      settle_d = settle_q - SW'(1);
    end else if (state_q == RUN && state_d == RUN) begin
      if (smp_update_i) begin
        din_d     = smp_i;
        din_upd_d = 1'b1;
      end
      if (avg_dout_update_i) begin
        // Decimation keeps counting while held so display cadence is unchanged.
        if (dec_q == DW'(OUT_DIV - 1)) begin
          dec_d = '0;
          if (!hold_i) begin
            res_d     = avg_dout_i;
            res_upd_d = 1'b1;
          end
        end else begin
          dec_d = dec_q + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_q  <= '0;
      dec_q     <= '0;
      din_q     <= '0;
      res_q     <= '0;
      din_upd_q <= 1'b0;
      res_upd_q <= 1'b0;
      clr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      settle_q  <= settle_d;
      dec_q     <= dec_d;
      din_q     <= din_d;
      res_q     <= res_d;
      din_upd_q <= din_upd_d;
      res_upd_q <= res_upd_d;
      clr_q     <= clr_d;
      busy_q    <= busy_d;
    end
  end

  assign tmo_clr = (state_d == IDLE) || (state_d == CLEAR);
  assign tmo_run = (state_q != IDLE);

  ste_timeout_cnt #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmo_clr),
    .run_i    (tmo_run),
    .restart_i(smp_update_i),
    .flag_o   (tmo_flag)
  );

  assign avg_din_o        = din_q;
  assign avg_din_update_o = din_upd_q;
  assign avg_clr_o        = clr_q;
  assign res_o            = res_q;
  assign res_update_o     = res_upd_q;
  assign busy_o           = busy_q;
  assign timeout_o        = tmo_flag;

endmodule

// File: tb/tb_ste_avg_ctrl.sv
// Scenario tasks plus a randomized run, all checked against a phase-level
// reference model of the controller.
module tb_ste_avg_ctrl;

  localparam int DATA_W      = 16;
  localparam int SETTLE_N    = 4;
  localparam int OUT_DIV     = 8;
  localparam int TIMEOUT_CYC = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable_i = 1'b0;
  logic              cfg_change_i = 1'b0;
  logic              hold_i = 1'b0;
  logic [DATA_W-1:0] smp_i = '0;
  logic              smp_update_i = 1'b0;
  logic [DATA_W-1:0] avg_dout_i = '0;
  logic              avg_dout_update_i = 1'b0;
  logic [DATA_W-1:0] avg_din_o, res_o;
  logic              avg_din_update_o, avg_clr_o, res_update_o, busy_o, timeout_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ste_avg_ctrl #(
    .DATA_W(DATA_W), .SETTLE_N(SETTLE_N), .OUT_DIV(OUT_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .cfg_change_i(cfg_change_i),
    .hold_i(hold_i), .smp_i(smp_i), .smp_update_i(smp_update_i),
    .avg_din_o(avg_din_o), .avg_din_update_o(avg_din_update_o), .avg_clr_o(avg_clr_o),
    .avg_dout_i(avg_dout_i), .avg_dout_update_i(avg_dout_update_i),
    .res_o(res_o), .res_update_o(res_update_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  // Reference model: phase 0 idle, 1 clear, 2 settle, 3 run.
  int m_ph, m_left, m_outs, m_quiet;
  logic m_to, m_clr, m_busy, m_din_v, m_res_v;
  logic [DATA_W-1:0] m_din, m_res;

  task automatic model_reset();
    m_ph = 0; m_left = 0; m_outs = 0; m_quiet = 0;
    m_to = 0; m_clr = 0; m_busy = 0; m_din_v = 0; m_res_v = 0;
    m_din = '0; m_res = '0;
  endtask

  task automatic model_edge();
    int prev = m_ph;
    m_din_v = 0;
    m_res_v = 0;
    if (!enable_i) m_ph = 0;
    else if (prev == 0 || cfg_change_i) m_ph = 1;
    else if (prev == 1) begin
      m_left = SETTLE_N;
      m_outs = 0;
      m_ph = (SETTLE_N == 0) ? 3 : 2;
    end else if (prev == 2) begin
      if (smp_update_i) begin
        m_left--;
        if (m_left == 0) m_ph = 3;
      end
    end else begin
      if (smp_update_i) begin m_din = smp_i; m_din_v = 1; end
      if (avg_dout_update_i) begin
        m_outs++;
        if (m_outs % OUT_DIV == 0 && !hold_i) begin m_res = avg_dout_i; m_res_v = 1; end
      end
    end
    if (m_ph <= 1) begin m_quiet = 0; m_to = 0; end
    else if (smp_update_i) m_quiet = 0;
    else begin
      m_quiet++;
      if (m_quiet >= TIMEOUT_CYC) m_to = 1;
    end
    m_clr  = (m_ph == 1);
    m_busy = (m_ph == 1) || (m_ph == 2);
  endtask

  task automatic step();
    if (rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    step(); step();
    checks++;
    if ({res_o, avg_din_o, avg_din_update_o, avg_clr_o, res_update_o, busy_o, timeout_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got res=%h din=%h flags=%b%b%b%b%b required all 0", res_o, avg_din_o,
               avg_din_update_o, avg_clr_o, res_update_o, busy_o, timeout_o);
    end
    rst = 0;
    step();
    checks++;
    if (avg_clr_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet got clr=%b busy=%b required 0 0", avg_clr_o, busy_o);
    end
  endtask

  task automatic test_start_settle();
    enable_i = 1; step();
    checks++;
    if (avg_clr_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL start_clear got clr=%b busy=%b required 1 1", avg_clr_o, busy_o);
    end
    step();
    checks++;
    if (avg_clr_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL clear_one_cycle got clr=%b busy=%b required 0 1", avg_clr_o, busy_o);
    end
    for (int v = 1; v <= 4; v++) begin
      repeat ($urandom_range(0, 2)) step();
      smp_i = DATA_W'(v); smp_update_i = 1; step(); smp_update_i = 0;
      checks++;
      if (avg_din_update_o !== 1'b0) begin
        failures++;
        $display("FAIL settle_discard sample=%0d got upd=%b required 0", v, avg_din_update_o);
      end
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL settle_done got busy=%b required 0", busy_o);
    end
    smp_i = 5; smp_update_i = 1; step(); smp_update_i = 0;
    checks++;
    if (avg_din_update_o !== 1'b1 || avg_din_o !== 16'd5) begin
      failures++;
      $display("FAIL first_forward got upd=%b din=%0d required 1 5", avg_din_update_o, avg_din_o);
    end
    step();
    checks++;
    if (avg_din_update_o !== 1'b0) begin
      failures++;
      $display("FAIL forward_pulse_width got upd=%b required 0", avg_din_update_o);
    end
  endtask

  task automatic test_decimation();
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 3)) begin
        smp_update_i = ($urandom_range(0, 1) == 1); smp_i = DATA_W'($urandom);
        step(); smp_update_i = 0;
        if (res_update_o === 1'b1) pulses++;
        checks++;
        if (avg_din_update_o !== m_din_v || avg_din_o !== m_din) begin
          failures++;
          $display("FAIL dec_forward got upd=%b din=%h required %b %h", avg_din_update_o, avg_din_o, m_din_v, m_din);
        end
      end
      avg_dout_i = DATA_W'(100 + i); avg_dout_update_i = 1; step(); avg_dout_update_i = 0;
      if (res_update_o === 1'b1) pulses++;
      checks++;
      if (i == 7 || i == 15) begin
        if (res_update_o !== 1'b1 || res_o !== DATA_W'(100 + i)) begin
          failures++;
          $display("FAIL dec_publish out=%0d got upd=%b res=%0d required 1 %0d", i + 1, res_update_o, res_o, 100 + i);
        end
      end else if (res_update_o !== 1'b0) begin
        failures++;
        $display("FAIL dec_early out=%0d got upd=%b required 0", i + 1, res_update_o);
      end
    end
    step();
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL dec_pulse_count got %0d required 2", pulses);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 16; i++) begin
      hold_i = (i < 8);
      repeat ($urandom_range(0, 2)) step();
      avg_dout_i = DATA_W'(100 + i); avg_dout_update_i = 1; step(); avg_dout_update_i = 0;
      checks++;
      if (i == 15) begin
        if (res_update_o !== 1'b1 || res_o !== 16'd115) begin
          failures++;
          $display("FAIL hold_release got upd=%b res=%0d required 1 115", res_update_o, res_o);
        end
      end else if (res_update_o !== 1'b0 || res_o !== 16'd115) begin
        failures++;
        $display("FAIL hold_frozen out=%0d got upd=%b res=%0d required 0 115", i + 1, res_update_o, res_o);
      end
    end
    hold_i = 0;
  endtask

  task automatic test_reconfig();
    for (int i = 0; i < 5; i++) begin
      avg_dout_i = DATA_W'($urandom); avg_dout_update_i = 1; step(); avg_dout_update_i = 0;
    end
    cfg_change_i = 1; smp_update_i = 1; smp_i = 16'h1234; step();
    cfg_change_i = 0; smp_update_i = 0;
    checks++;
    if (avg_din_update_o !== 1'b0 || avg_clr_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL reconfig_clear got upd=%b clr=%b busy=%b required 0 1 1", avg_din_update_o, avg_clr_o, busy_o);
    end
    step();
    for (int v = 0; v < 5; v++) begin
      smp_i = DATA_W'(50 + v); smp_update_i = 1; step(); smp_update_i = 0;
      checks++;
      if (avg_din_update_o !== (v == 4)) begin
        failures++;
        $display("FAIL reconfig_settle sample=%0d got upd=%b required %b", v + 1, avg_din_update_o, v == 4);
      end
    end
    for (int i = 0; i < 8; i++) begin
      avg_dout_i = DATA_W'(200 + i); avg_dout_update_i = 1; step(); avg_dout_update_i = 0;
      checks++;
      if (res_update_o !== (i == 7) || (i == 7 && res_o !== 16'd207)) begin
        failures++;
        $display("FAIL reconfig_decim out=%0d got upd=%b res=%0d required %b", i + 1, res_update_o, res_o, i == 7);
      end
    end
  endtask

  task automatic test_timeout();
    cfg_change_i = 1; step(); cfg_change_i = 0;
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_cleared_start got %b required 0", timeout_o);
    end
    step();
    repeat (SETTLE_N + 1) begin
      smp_i = DATA_W'($urandom); smp_update_i = 1; step(); smp_update_i = 0;
    end
    for (int c = 1; c <= 22; c++) begin
      step();
      checks++;
      if (timeout_o !== (c >= TIMEOUT_CYC)) begin
        failures++;
        $display("FAIL timeout_cycle c=%0d got %b required %b", c, timeout_o, c >= TIMEOUT_CYC);
      end
    end
    smp_update_i = 1; step(); smp_update_i = 0;
    checks++;
    if (timeout_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky got %b required 1", timeout_o);
    end
    cfg_change_i = 1; step(); cfg_change_i = 0;
    checks++;
    if (timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL timeout_cfg_clear got %b required 0", timeout_o);
    end
  endtask

  task automatic test_disable();
    step();
    repeat (2) begin
      smp_update_i = 1; step(); smp_update_i = 0;
    end
    enable_i = 0; smp_update_i = 1; step();
    checks++;
    if (avg_clr_o !== 1'b0 || busy_o !== 1'b0 || avg_din_update_o !== 1'b0) begin
      failures++;
      $display("FAIL disable_idle got clr=%b busy=%b upd=%b required 0 0 0", avg_clr_o, busy_o, avg_din_update_o);
    end
    cfg_change_i = 1; step(); cfg_change_i = 0; smp_update_i = 0;
    checks++;
    if (avg_clr_o !== 1'b0 || avg_din_update_o !== 1'b0 || res_o !== 16'd207) begin
      failures++;
      $display("FAIL idle_ignore got clr=%b upd=%b res=%0d required 0 0 207", avg_clr_o, avg_din_update_o, res_o);
    end
  endtask

  task automatic test_async_reset();
    enable_i = 1; step(); step();
    repeat (SETTLE_N) begin
      smp_update_i = 1; step(); smp_update_i = 0;
    end
    smp_i = 16'hBEEF; smp_update_i = 1; step(); smp_update_i = 0;
    checks++;
    if (avg_din_update_o !== 1'b1 || avg_din_o !== 16'hBEEF) begin
      failures++;
      $display("FAIL pre_reset_forward got upd=%b din=%h required 1 beef", avg_din_update_o, avg_din_o);
    end
    rst = 1;
    #2;
    checks++;
    if ({res_o, avg_din_o, avg_din_update_o, avg_clr_o, res_update_o, busy_o, timeout_o} !== '0) begin
      failures++;
      $display("FAIL async_reset got res=%h din=%h upd=%b required all 0", res_o, avg_din_o, avg_din_update_o);
    end
    enable_i = 0;
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
  endtask

  task automatic test_random();
    bit slow = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) slow = !slow;
      if ($urandom_range(0, 299) == 0) enable_i = 0;
      else if (!enable_i && $urandom_range(0, 9) == 0) enable_i = 1;
      cfg_change_i = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) hold_i = ~hold_i;
      smp_update_i = slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1) == 1);
      smp_i = DATA_W'($urandom);
      avg_dout_update_i = ($urandom_range(0, 2) == 0);
      avg_dout_i = DATA_W'($urandom);
      step();
      checks++;
      if ({avg_din_update_o, avg_clr_o, res_update_o, busy_o, timeout_o} !== {m_din_v, m_clr, m_res_v, m_busy, m_to}
          || res_o !== m_res || avg_din_o !== m_din) begin
        failures++;
        $display("FAIL random c=%0d got upd/clr/res_upd/busy/to=%b%b%b%b%b res=%h din=%h required %b%b%b%b%b %h %h",
                 c, avg_din_update_o, avg_clr_o, res_update_o, busy_o, timeout_o, res_o, avg_din_o,
                 m_din_v, m_clr, m_res_v, m_busy, m_to, m_res, m_din);
      end
    end
    cfg_change_i = 0; smp_update_i = 0; avg_dout_update_i = 0; hold_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_settle();
    test_decimation();
    test_hold();
    test_reconfig();
    test_timeout();
    test_disable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ste_avg_ctrl.md
Name: ste_avg_ctrl

Overview:
- Sequencing controller between the multimeter ADC sample stream and the averaging filter (ste_avg_fir).
- On enable or measurement-configuration change, it clears the averager and discards settling samples. It then forwards samples, decimates the averager output to the display rate, and supports display hold.
- It also flags a sample-stream timeout.

Parameters:
- DATA_W, 16, sample/result width.
- SETTLE_N, 4, samples discarded after each clear (range 0..255).
- OUT_DIV, 8, averager outputs per published result (range 1..255).
- TIMEOUT_CYC, 1000000, clk cycles without smp_update_i before timeout (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- enable_i  in  1  measurement enable (level)
- cfg_change_i  in  1  one-cycle pulse: range/mode changed
- hold_i  in  1  display hold (level)
- smp_i  in  DATA_W  ADC sample
- smp_update_i  in  1  sample-valid pulse
- avg_din_o  out  DATA_W  sample to averager
- avg_din_update_o  out  1  sample-valid pulse to averager
- avg_clr_o  out  1  averager clear pulse
- avg_dout_i  in  DATA_W  averaged value
- avg_dout_update_i  in  1  averaged-value valid pulse
- res_o  out  DATA_W  published result
- res_update_o  out  1  published-result pulse
- busy_o  out  1  high in CLEAR/SETTLE
- timeout_o  out  1  sticky sample-timeout flag

Behaviour:
- Interface: one clock (clk); reset asynchronous, active-high (rst).
- Reset values: state IDLE, all counters 0, every output 0 (res_o = 0).
- All outputs are registered.
- States: IDLE, CLEAR, SETTLE, RUN.
- IDLE:
  - No forwarding.
  - enable_i=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - avg_clr_o=1.
  - Load settle counter = SETTLE_N; clear decimation counter.
  - Next state: SETTLE if SETTLE_N>0, else RUN.
- SETTLE:
  - Each smp_update_i decrements the settle counter; the sample is not forwarded.
  - Counter reaching 0 -> RUN. The sample that brings the counter to 0 is also discarded.
- RUN:
  - Each smp_update_i yields avg_din_o=smp_i and avg_din_update_o=1 in the next cycle (1-cycle latency).
  - Each avg_dout_update_i increments the decimation counter.
  - On the OUT_DIV-th output: counter -> 0, res_o=avg_dout_i, res_update_o=1 next cycle, unless hold_i=1.
  - With hold_i=1, res_o is frozen and no pulse is emitted, but the counter still runs.
- Priority, highest first:
  1. enable_i=0 -> IDLE from any state, with no clear pulse. res_o is retained.
  2. cfg_change_i=1 while enabled -> CLEAR from any non-IDLE state. In IDLE it is ignored.
  3. Sample or averager events.
- A sample coinciding with cfg_change_i is dropped.
- avg_dout_update_i outside RUN is ignored.
- busy_o = (state==CLEAR or SETTLE).
- Timeout:
  - The cycle counter runs whenever state!=IDLE and resets on every smp_update_i.
  - When it reaches TIMEOUT_CYC-1 without a sample, timeout_o is set and the counter saturates.
  - timeout_o clears on entry to CLEAR or IDLE. A subsequent sample resets the counter but does not clear the flag.
- Counter widths are derived via $clog2 of the parameter, with +1 where a value equal to the parameter must be held.
- Data is passed unmodified; no arithmetic on samples.

Decomposition:
- Package ste_avg_pkg holds:
  - typedef enum logic [1:0] {IDLE, CLEAR, SETTLE, RUN} avg_ctrl_state_t;
  - localparam defaults for SETTLE_N, OUT_DIV, TIMEOUT_CYC.
- One sub-module, ste_timeout_cnt: parameterised restartable saturating counter with a sticky flag and clear input. It is reusable by other multimeter front-end blocks.
- The rest is a single FSM plus counters.

Test Plan:
- Reset/start: rst pulse, then enable_i=1 with SETTLE_N=4.
  - avg_clr_o high for exactly 1 cycle; busy_o=1.
  - First 4 samples (values 1..4) not forwarded.
  - Sample 5 appears on avg_din_o 1 cycle after its pulse.
- Decimation: OUT_DIV=8; feed 16 averager outputs with values 100..115.
  - Exactly 2 res_update_o pulses.
  - res_o=107, then res_o=115.
- Hold: hold_i=1 across the 8th output (value 107).
  - No pulse; res_o keeps its previous value.
  - After hold_i=0, the next 8th output (value 115) publishes 115.
- Reconfigure mid-run: cfg_change_i pulsed in the same cycle as smp_update_i after 5 averager outputs.
  - That sample is dropped; avg_clr_o pulses.
  - 4 samples are discarded again; the decimation count restarts from 0.
- Timeout: TIMEOUT_CYC=20, in RUN, no samples.
  - timeout_o=1 at cycle 20 after the last sample.
  - Stays 1 after a new sample; clears on cfg_change_i.
- Disable/async reset: enable_i=0 in SETTLE -> IDLE with no clr pulse and no forwarding.
  - rst asserted mid-RUN drops all outputs to 0 immediately, without waiting for a clock edge.
